// File: rtl/q294_nibble_serial_if.sv
// Handshake and share buses for the nibble-serial Q294 driver.
// The producer/consumer side is the master and the datapath is the slave.
interface q294_nibble_serial_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x1_in;
    logic [W-1:0] x2_in;
    logic [W-1:0] x3_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y1_out;
    logic [W-1:0] y2_out;
    logic [W-1:0] y3_out;
    logic         busy;

    modport master (
        output in_valid, x1_in, x2_in, x3_in, out_ready,
        input  in_ready, out_valid, y1_out, y2_out, y3_out, busy
    );

    modport slave (
        input  in_valid, x1_in, x2_in, x3_in, out_ready,
        output in_ready, out_valid, y1_out, y2_out, y3_out, busy
    );
endinterface

// File: rtl/q294_nibble_serial.sv
// Nibble-serial driver around one 3-share Q294 TI instance (Midori64 TI datapath).
// Flops on both sides of Q294 stop glitches crossing shares between cycles.

// One output share of Q294. Sees only shares (a, b) = (x_{i+1}, x_{i+2}),
// never x_i, which keeps the sharing non-complete.
module q294_share (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [3:0] o_y
);
    // Unshared Q: q[r] = x[r] ^ x[r+1]&x[r+2] (indices mod 4)
    for (genvar r = 0; r < 4; r++) begin : g_bit
        localparam int P = (r + 1) % 4;
        localparam int Q = (r + 2) % 4;
        assign o_y[r] = i_a[r] ^ (i_a[P] & i_a[Q]) ^ (i_a[P] & i_b[Q]) ^ (i_b[P] & i_a[Q]);
    end
endmodule

module q294 (
    input  logic [2:0][3:0] i_x,
    output logic [2:0][3:0] o_y
);
    for (genvar s = 0; s < 3; s++) begin : g_share
        q294_share u_share (
            .i_a (i_x[(s + 1) % 3]),
            .i_b (i_x[(s + 2) % 3]),
            .o_y (o_y[s])
        );
    end
endmodule

module q294_nibble_serial #(
    parameter int NUM_NIBBLES = 16,
    parameter int CNT_W       = 4
) (
    input logic               clk,
    input logic               rst_n,
    q294_nibble_serial_if.slave bus
);
    localparam int W = 4 * NUM_NIBBLES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0][W-1:0]     r_x;
    logic [2:0][W-1:0]     r_y;
    logic [2:0][3:0]       w_qx;
    logic [2:0][3:0]       w_qy;
    logic                  w_accept;
    logic                  w_last;

    always_comb begin
        for (int s = 0; s < 3; s++) w_qx[s] = r_x[s][3:0];
    end

    q294 u_q294 (
        .i_x (w_qx),
        .o_y (w_qy)
    );

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == CNT_W'(NUM_NIBBLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_x[0] <= bus.x1_in;
                r_x[1] <= bus.x2_in;
                r_x[2] <= bus.x3_in;
                r_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                // Input drains LSB-nibble first, result enters at the top, so nibble i maps to nibble i
                for (int s = 0; s < 3; s++) begin
                    r_x[s] <= r_x[s] >> 4;
                    r_y[s] <= {w_qy[s], r_y[s][W-1:4]};
                end
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state == S_RUN);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.y1_out    = r_y[0];
    assign bus.y2_out    = r_y[1];
    assign bus.y3_out    = r_y[2];
endmodule

// File: tb/tb_q294_nibble_serial.sv
// Scoreboard bench for q294_nibble_serial: driver pushes model results,
// a negedge monitor pops and compares on each output handshake.
module tb_q294_nibble_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    q294_nibble_serial_if #(.W(64)) bus ();

    q294_nibble_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] y1, y2, y3, yx;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   vec = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Unshared quadratic Q on one nibble.
    function automatic logic [3:0] qf(input logic [3:0] x);
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = x[i] ^ (x[(i + 1) % 4] & x[(i + 2) % 4]);
        return r;
    endfunction

    // Share i sees (a,b) = (x_{i+1}, x_{i+2}); for quadratic Q its output is Q(a^b)^Q(b).
    function automatic exp_t model(input logic [63:0] a, b, c, input int acc);
        exp_t e;
        for (int n = 0; n < 16; n++) begin
            e.y1[4*n +: 4] = qf(b[4*n +: 4] ^ c[4*n +: 4]) ^ qf(c[4*n +: 4]);
            e.y2[4*n +: 4] = qf(c[4*n +: 4] ^ a[4*n +: 4]) ^ qf(a[4*n +: 4]);
            e.y3[4*n +: 4] = qf(a[4*n +: 4] ^ b[4*n +: 4]) ^ qf(b[4*n +: 4]);
            e.yx[4*n +: 4] = qf(a[4*n +: 4] ^ b[4*n +: 4] ^ c[4*n +: 4]);
        end
        e.acc = acc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // Monitor
    initial begin
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (bus.out_valid && !prev_ov) begin
                    if (sb.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
                    else chk("latency", 64'(cyc), 64'(sb[0].acc + 16));
                end
                if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("y1", bus.y1_out, e.y1);
                    chk("y2", bus.y2_out, e.y2);
                    chk("y3", bus.y3_out, e.y3);
                    chk("xorsum", bus.y1_out ^ bus.y2_out ^ bus.y3_out, e.yx);
                end
                prev_ov = bus.out_valid;
            end
        end
    end

    // Tasks are entered and left at posedge+1.
    task automatic send(input logic [63:0] a, b, c, output int acc);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.x1_in = a;
        bus.x2_in = b;
        bus.x3_in = c;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        sb.push_back(model(a, b, c, cyc));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_y"}, bus.y1_out | bus.y2_out | bus.y3_out, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev_acc, n;
        logic [63:0] h1, h2, h3;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.x1_in = '0;
        bus.x2_in = '0;
        bus.x3_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst_n = 1'b1;

        // Zero state
        send(64'd0, 64'd0, 64'd0, acc);
        drain();

        // Fixed correctness sweep
        send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, acc);
        drain();

        // New data offered mid-RUN must be ignored
        send(r64(), r64(), r64(), acc);
        repeat (5) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.x1_in = r64();
        bus.x2_in = r64();
        bus.x3_in = r64();
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
        chk("busy_flag", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: hold DONE for 20 cycles
        bus.out_ready = 1'b0;
        send(r64(), r64(), r64(), acc);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        h1 = bus.y1_out;
        h2 = bus.y2_out;
        h3 = bus.y3_out;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.x1_in = r64();
            @(posedge clk); #1;
            chk("bp_stable", {bus.y1_out ^ h1} | {bus.y2_out ^ h2} | {bus.y3_out ^ h3}, 64'd0);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_held", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_idle_valid", 64'(bus.out_valid), 64'd0);
        drain();

        // Reset at RUN nibble 7 discards the block
        send(r64(), r64(), r64(), acc);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("midrun");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(r64(), r64(), r64(), acc);
        drain();

        // Back-to-back random blocks
        prev_acc = -1;
        for (int i = 0; i < 100; i++) begin
            send(r64(), r64(), r64(), acc);
            if (i > 0) chk("period", 64'(acc - prev_acc), 64'd18);
            prev_acc = acc;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
